// File: rtl/rx_word_align_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_align_pkg
// Shared definitions for the receive word-alignment controller:
//   - WORD_W            : width of a 10b code group
//   - COMMA_P / COMMA_N : K28.5 comma in running disparity minus / plus
//   - rx_align_state_t  : alignment state machine encoding
// ---------------------------------------------------------------------------
package rx_align_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] COMMA_P = 10'b0011111010;
    localparam logic [WORD_W-1:0] COMMA_N = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_align_state_t;

endpackage

// File: rtl/rx_word_align_ctrl_if.sv
// ---------------------------------------------------------------------------
// rx_word_align_ctrl_if
// Groups the deserializer window and the aligned-word outputs.
//   RxParallel_10 : 10b sliding window from the SIPO (into the controller)
//   RxWord        : aligned code group, registered
//   WordValid     : one-cycle strobe qualifying RxWord
//   Locked        : alignment is locked
//   CommaDet      : a comma was seen in the window on the previous cycle
// Modports:
//   master : window source / word consumer (deserializer + decoder side)
//   slave  : the alignment controller
// ---------------------------------------------------------------------------
interface rx_word_align_ctrl_if;
    import rx_align_pkg::*;

    logic [WORD_W-1:0] RxParallel_10;
    logic [WORD_W-1:0] RxWord;
    logic              WordValid;
    logic              Locked;
    logic              CommaDet;

    modport master (
        output RxParallel_10,
        input  RxWord,
        input  WordValid,
        input  Locked,
        input  CommaDet
    );

    modport slave (
        input  RxParallel_10,
        output RxWord,
        output WordValid,
        output Locked,
        output CommaDet
    );

endinterface

// File: rtl/rx_word_align_ctrl_comma_detect.sv
// ---------------------------------------------------------------------------
// rx_comma_detect
// Combinational bit-exact comma compare of the sliding window.
//   window    : 10b window from the deserializer
//   comma_hit : window equals a recognised comma
// Macro RX_ALIGN_BOTH_DISP_EN: when defined, the RD+ form of K28.5 is also
// recognised; otherwise only the RD- form matches and RD+ is plain data.
// ---------------------------------------------------------------------------
module rx_comma_detect
    import rx_align_pkg::*;
(
    input  logic [WORD_W-1:0] window,
    output logic              comma_hit
);

`ifdef RX_ALIGN_BOTH_DISP_EN
    assign comma_hit = (window == COMMA_P) || (window == COMMA_N);
`else
    assign comma_hit = (window == COMMA_P);
`endif

endmodule

// File: rtl/rx_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// rx_word_align_ctrl
// Word-alignment controller beside the SIPO deserializer, on the bit clock.
// Finds the K28.5 comma, fixes the 10b word boundary from it, emits one
// strobed code group per word and tracks lock / loss of sync.
// Ports:
//   BitCLK : bit clock, all state on its rising edge
//   Reset  : synchronous, active-low
//   rx     : rx_word_align_ctrl_if.slave (window in, aligned word out)
// Parameters:
//   LOCK_COMMAS : consecutive aligned commas needed for lock (>=1)
//   UNLOCK_ERRS : misaligned commas that drop lock (>=1)
// Macro RX_ALIGN_BOTH_DISP_EN (see rx_comma_detect) widens the comma match.
// ---------------------------------------------------------------------------
module rx_word_align_ctrl
    import rx_align_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int UNLOCK_ERRS = 4
)
(
    input  logic                 BitCLK,
    input  logic                 Reset,
    rx_word_align_ctrl_if.slave  rx
);

    localparam int GOOD_W = (LOCK_COMMAS < 1) ? 1 : $clog2(LOCK_COMMAS + 1);
    localparam int ERR_W  = (UNLOCK_ERRS < 1) ? 1 : $clog2(UNLOCK_ERRS + 1);
    localparam int BIT_W  = $clog2(WORD_W);

    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WORD_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COMMAS);
    localparam logic [ERR_W-1:0]  ERR_TARGET  = ERR_W'(UNLOCK_ERRS);
    localparam logic [GOOD_W-1:0] GOOD_MAX    = {GOOD_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

    rx_align_state_t   state_reg, state_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next, good_inc;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next, err_inc;
    logic [WORD_W-1:0] rx_word_reg, rx_word_next;
    logic              word_valid_reg, word_valid_next;
    logic              comma_det_reg, comma_det_next;
    logic              comma_hit;
    logic              aligned;

    rx_comma_detect u_comma_detect (
        .window    (rx.RxParallel_10),
        .comma_hit (comma_hit)
    );

    assign aligned = (bit_cnt_reg == BIT_LAST);

    // Saturating increments: counters hold at all-ones rather than wrap.
    assign good_inc = (good_cnt_reg == GOOD_MAX) ? good_cnt_reg : good_cnt_reg + 1'b1;
    assign err_inc  = (err_cnt_reg  == ERR_MAX)  ? err_cnt_reg  : err_cnt_reg  + 1'b1;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = aligned ? '0 : bit_cnt_reg + 1'b1;
        good_cnt_next   = good_cnt_reg;
        err_cnt_next    = err_cnt_reg;
        rx_word_next    = rx_word_reg;
        word_valid_next = 1'b0;
        comma_det_next  = comma_hit;

        unique case (state_reg)
            HUNT: begin
                if (comma_hit) begin
                    // The comma itself is the first aligned word; the new
                    // boundary repeats WORD_W cycles after this one.
                    rx_word_next    = rx.RxParallel_10;
                    word_valid_next = 1'b1;
                    bit_cnt_next    = '0;
                    good_cnt_next   = GOOD_W'(1);
                    err_cnt_next    = '0;
                    state_next      = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
                end
            end

            VERIFY: begin
                if (aligned) begin
                    rx_word_next    = rx.RxParallel_10;
                    word_valid_next = 1'b1;
                end
                if (comma_hit && aligned) begin
                    good_cnt_next = good_inc;
                    if (good_inc == GOOD_TARGET) begin
                        state_next   = LOCKED;
                        err_cnt_next = '0;
                    end
                end else if (comma_hit) begin
                    // Off-boundary comma while still verifying: trust the
                    // newest comma and restart the count from it.
                    rx_word_next    = rx.RxParallel_10;
                    word_valid_next = 1'b1;
                    bit_cnt_next    = '0;
                    good_cnt_next   = GOOD_W'(1);
                end
            end

            LOCKED: begin
                if (aligned) begin
                    rx_word_next    = rx.RxParallel_10;
                    word_valid_next = 1'b1;
                end
                if (comma_hit && aligned) begin
                    err_cnt_next = '0;
                end else if (comma_hit) begin
                    // Boundary stays put when locked; only the error
                    // tally reacts, and dropping lock does not realign.
                    err_cnt_next = err_inc;
                    if (err_inc == ERR_TARGET) begin
                        state_next    = HUNT;
                        good_cnt_next = '0;
                        err_cnt_next  = '0;
                    end
                end
            end

            default: begin
                state_next = HUNT;
            end
        endcase
    end

    always_ff @(posedge BitCLK) begin
        if (!Reset) begin
            state_reg      <= HUNT;
            bit_cnt_reg    <= '0;
            good_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
            rx_word_reg    <= '0;
            word_valid_reg <= 1'b0;
            comma_det_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            err_cnt_reg    <= err_cnt_next;
            rx_word_reg    <= rx_word_next;
            word_valid_reg <= word_valid_next;
            comma_det_reg  <= comma_det_next;
        end
    end

    assign rx.RxWord    = rx_word_reg;
    assign rx.WordValid = word_valid_reg;
    assign rx.Locked    = (state_reg == LOCKED);
    assign rx.CommaDet  = comma_det_reg;

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_word_align_ctrl
// Directed bench for rx_word_align_ctrl. Windows are driven directly one per
// bit clock; filler windows are random values that are never a comma.
// A second instance with LOCK_COMMAS=1 shares the window to cover the
// lock-on-first-comma path.
// ---------------------------------------------------------------------------
module tb_rx_word_align_ctrl;
    import rx_align_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rx_word_align_ctrl_if rx_if();
    rx_word_align_ctrl_if rx1_if();

    assign rx1_if.RxParallel_10 = rx_if.RxParallel_10;

    rx_word_align_ctrl #(.LOCK_COMMAS(3), .UNLOCK_ERRS(4)) dut (
        .BitCLK (clk),
        .Reset  (rst_n),
        .rx     (rx_if)
    );

    rx_word_align_ctrl #(.LOCK_COMMAS(1), .UNLOCK_ERRS(4)) dut1 (
        .BitCLK (clk),
        .Reset  (rst_n),
        .rx     (rx1_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] rand_data();
        logic [9:0] v;
        v = 10'($urandom_range(0, 1023));
        if (v == COMMA_P || v == COMMA_N) v = v ^ 10'h001;
        return v;
    endfunction

    // Present one window, let the rising edge sample it, settle 1 time unit.
    task automatic drive(input logic [9:0] w);
        rx_if.RxParallel_10 = w;
        @(posedge clk);
        #1;
        if (rx_if.WordValid === 1'b1)
            $display("[%0t] word=%010b locked=%0b commadet=%0b", $time,
                     rx_if.RxWord, rx_if.Locked, rx_if.CommaDet);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive((i == 1) ? COMMA_P : rand_data());
            n_checks++;
            if ({rx_if.RxWord, rx_if.WordValid, rx_if.Locked, rx_if.CommaDet} !== 13'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: got word=%b wv=%b lk=%b cd=%b, expected all 0",
                         i, rx_if.RxWord, rx_if.WordValid, rx_if.Locked, rx_if.CommaDet);
            end
            n_checks++;
            if (rx1_if.Locked !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_dut1_locked cyc=%0d: got %b expected 0", i, rx1_if.Locked);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(rand_data());
            n_checks++;
            if (rx_if.WordValid !== 1'b0 || rx_if.CommaDet !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc=%0d: got wv=%b cd=%b expected 0 0",
                         i, rx_if.WordValid, rx_if.CommaDet);
            end
        end
    endtask

    // Comma every 10 cycles; lock after the third. Leaves the next edge on a boundary.
    task automatic test_acquisition();
        logic [9:0] w;
        logic       is_b;
        for (int i = 0; i < 3; i++) drive(rand_data());
        for (int t = 0; t < 30; t++) begin
            is_b = (t % 10 == 0);
            w = is_b ? COMMA_P : rand_data();
            drive(w);
            n_checks++;
            if (rx_if.WordValid !== is_b) begin
                n_fail++;
                $display("FAIL acq_wordvalid t=%0d: got %b expected %b", t, rx_if.WordValid, is_b);
            end
            if (is_b) begin
                n_checks++;
                if (rx_if.RxWord !== 10'b0011111010) begin
                    n_fail++;
                    $display("FAIL acq_rxword t=%0d: got %b expected 0011111010", t, rx_if.RxWord);
                end
            end
            n_checks++;
            if (rx_if.Locked !== (t >= 20)) begin
                n_fail++;
                $display("FAIL acq_locked t=%0d: got %b expected %b", t, rx_if.Locked, (t >= 20));
            end
            n_checks++;
            if (rx_if.CommaDet !== is_b) begin
                n_fail++;
                $display("FAIL acq_commadet t=%0d: got %b expected %b", t, rx_if.CommaDet, is_b);
            end
            if (t == 0) begin
                n_checks++;
                if (rx1_if.Locked !== 1'b1 || rx1_if.WordValid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL acq_lock1 t=0: got lk=%b wv=%b expected 1 1",
                             rx1_if.Locked, rx1_if.WordValid);
                end
            end
        end
    endtask

    // Misaligned comma at +4, aligned comma at 10, then three more misaligned:
    // lock survives only if the aligned comma cleared the error tally.
    task automatic test_locked_misaligned();
        logic [9:0] w;
        logic       is_b;
        logic       is_c;
        for (int t = 0; t < 30; t++) begin
            is_b = (t % 10 == 0);
            is_c = (t == 4 || t == 10 || t == 12 || t == 14 || t == 16 || t == 20);
            w = is_c ? COMMA_P : rand_data();
            drive(w);
            n_checks++;
            if (rx_if.WordValid !== is_b) begin
                n_fail++;
                $display("FAIL mis_wordvalid t=%0d: got %b expected %b", t, rx_if.WordValid, is_b);
            end
            if (is_b) begin
                n_checks++;
                if (rx_if.RxWord !== w) begin
                    n_fail++;
                    $display("FAIL mis_rxword t=%0d: got %b expected %b", t, rx_if.RxWord, w);
                end
            end
            n_checks++;
            if (rx_if.Locked !== 1'b1) begin
                n_fail++;
                $display("FAIL mis_locked t=%0d: got %b expected 1", t, rx_if.Locked);
            end
            n_checks++;
            if (rx_if.CommaDet !== is_c) begin
                n_fail++;
                $display("FAIL mis_commadet t=%0d: got %b expected %b", t, rx_if.CommaDet, is_c);
            end
        end
    endtask

    // Four misaligned commas drop lock; comma at 13 realigns to a new phase.
    task automatic test_unlock();
        logic [9:0] w;
        logic       exp_wv;
        logic       exp_lk;
        logic       is_c;
        for (int t = 0; t < 43; t++) begin
            is_c   = (t == 2 || t == 4 || t == 6 || t == 8 || t == 13 || t == 23 || t == 33);
            w      = is_c ? COMMA_P : rand_data();
            exp_wv = (t == 0 || t == 13 || t == 23 || t == 33);
            exp_lk = (t < 8) || (t >= 33);
            drive(w);
            n_checks++;
            if (rx_if.WordValid !== exp_wv) begin
                n_fail++;
                $display("FAIL unlock_wordvalid t=%0d: got %b expected %b", t, rx_if.WordValid, exp_wv);
            end
            if (exp_wv) begin
                n_checks++;
                if (rx_if.RxWord !== w) begin
                    n_fail++;
                    $display("FAIL unlock_rxword t=%0d: got %b expected %b", t, rx_if.RxWord, w);
                end
            end
            n_checks++;
            if (rx_if.Locked !== exp_lk) begin
                n_fail++;
                $display("FAIL unlock_locked t=%0d: got %b expected %b", t, rx_if.Locked, exp_lk);
            end
        end
    endtask

    // Reset while locked with a comma on the boundary: reset wins.
    task automatic test_reset_mid();
        rst_n = 1'b0;
        drive(COMMA_P);
        n_checks++;
        if ({rx_if.RxWord, rx_if.WordValid, rx_if.Locked, rx_if.CommaDet} !== 13'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got word=%b wv=%b lk=%b cd=%b, expected all 0",
                     rx_if.RxWord, rx_if.WordValid, rx_if.Locked, rx_if.CommaDet);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(rand_data());
            n_checks++;
            if (rx_if.WordValid !== 1'b0 || rx_if.Locked !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_hunt cyc=%0d: got wv=%b lk=%b expected 0 0",
                         i, rx_if.WordValid, rx_if.Locked);
            end
        end
    endtask

    task automatic test_hunt_noise();
        for (int i = 0; i < 200; i++) begin
            drive(rand_data());
            n_checks++;
            if (rx_if.WordValid !== 1'b0 || rx_if.Locked !== 1'b0 || rx_if.CommaDet !== 1'b0) begin
                n_fail++;
                $display("FAIL hunt_noise cyc=%0d: got wv=%b lk=%b cd=%b expected 0 0 0",
                         i, rx_if.WordValid, rx_if.Locked, rx_if.CommaDet);
            end
        end
    endtask

    task automatic test_comma_n();
        logic is_b;
        logic exp_wv;
        logic exp_lk;
        for (int i = 0; i < 2; i++) drive(rand_data());
        for (int t = 0; t < 30; t++) begin
            is_b = (t % 10 == 0);
`ifdef RX_ALIGN_BOTH_DISP_EN
            exp_wv = is_b;
            exp_lk = (t >= 20);
`else
            exp_wv = 1'b0;
            exp_lk = 1'b0;
`endif
            drive(is_b ? COMMA_N : rand_data());
            n_checks++;
            if (rx_if.WordValid !== exp_wv) begin
                n_fail++;
                $display("FAIL comman_wordvalid t=%0d: got %b expected %b", t, rx_if.WordValid, exp_wv);
            end
            if (exp_wv) begin
                n_checks++;
                if (rx_if.RxWord !== COMMA_N) begin
                    n_fail++;
                    $display("FAIL comman_rxword t=%0d: got %b expected %b", t, rx_if.RxWord, COMMA_N);
                end
            end
            n_checks++;
            if (rx_if.Locked !== exp_lk || rx_if.CommaDet !== exp_wv) begin
                n_fail++;
                $display("FAIL comman_lock_cd t=%0d: got lk=%b cd=%b expected %b %b",
                         t, rx_if.Locked, rx_if.CommaDet, exp_lk, exp_wv);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rx_if.RxParallel_10 = '0;
        #1;
        test_reset();
        test_acquisition();
        test_locked_misaligned();
        test_unlock();
        test_reset_mid();
        test_hunt_noise();
        test_comma_n();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
